// File: rtl/alu_sequencer.sv
// alu_sequencer
// Issues one register-to-register instruction at a time to an external ALU
// and writes the result back into a small register file.
//
// Each instruction takes three cycles: IDLE (handshake), ISSUE (operands
// driven to the ALU) and WRITE (result pulse and conditional writeback).
// The next instruction can be accepted in the IDLE cycle that follows.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid / instr_ready     instruction handshake
//   instr_op/rd/rs1/rs2/cond      opcode, destination, sources, write condition
//   load_en/load_addr/load_data   direct register preload (IDLE only)
//   rd_addr / rd_data             combinational debug read of the register file
//   A, B, ALU_CONT, en            registered ALU operands, opcode and enable
//   ALU_OUT, Zero..LTS            ALU result and status flags
//   res_valid                     one-cycle completion pulse
//   res_data, res_flags           result and flags captured at the end of ISSUE
//   res_skipped                   write condition was false, no writeback
module alu_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [1:0]        instr_rd,
  input  logic [1:0]        instr_rs1,
  input  logic [1:0]        instr_rs2,
  input  logic [1:0]        instr_cond,
  input  logic              load_en,
  input  logic [1:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        ALU_CONT,
  output logic              en,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              Zero,
  input  logic              Pos,
  input  logic              Neg,
  input  logic              GT,
  input  logic              LT,
  input  logic              EQ,
  input  logic              GTS,
  input  logic              LTS,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [7:0]        res_flags,
  output logic              res_skipped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [4];
  logic              fz;
  logic              fn;
  logic [1:0]        rd_p0;
  logic [1:0]        cond_p0;

  // Write condition against the flags of the last executed instruction.
  function automatic logic cond_true(input logic [1:0] cond,
                                     input logic z, input logic n);
    case (cond)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = z;
      2'b10:   cond_true = ~z;
      default: cond_true = n;
    endcase
  endfunction

  // A preload in IDLE takes priority over a pending instruction.
  assign instr_ready = (state == IDLE) && !load_en && !rst;

  // Reads the stored value, so a write in progress is not visible until
  // the cycle after WRITE.
  assign rd_data = regs[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      fz          <= 1'b0;
      fn          <= 1'b0;
      rd_p0       <= '0;
      cond_p0     <= '0;
      en          <= 1'b0;
      A           <= '0;
      B           <= '0;
      ALU_CONT    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_flags   <= '0;
      res_skipped <= 1'b0;
    end else begin
      case (state)
        // IDLE -> ISSUE: latch the instruction and drive the ALU
        IDLE: begin
          res_valid <= 1'b0;
          if (load_en) begin
            regs[load_addr] <= load_data;
          end else if (instr_valid) begin
            rd_p0    <= instr_rd;
            cond_p0  <= instr_cond;
            A        <= regs[instr_rs1];
            B        <= regs[instr_rs2];
            ALU_CONT <= instr_op;
            en       <= 1'b1;
            state    <= ISSUE;
          end
        end
        // ISSUE -> WRITE: capture the ALU result and decide writeback
        ISSUE: begin
          en          <= 1'b0;
          A           <= '0;
          B           <= '0;
          ALU_CONT    <= '0;
          res_data    <= ALU_OUT;
          res_flags   <= {Zero, Pos, Neg, GT, LT, EQ, GTS, LTS};
          res_skipped <= !cond_true(cond_p0, fz, fn);
          res_valid   <= 1'b1;
          state       <= WRITE;
        end
        // WRITE -> IDLE: commit result and flags unless skipped
        WRITE: begin
          res_valid <= 1'b0;
          if (!res_skipped) begin
            regs[rd_p0] <= res_data;
            fz          <= res_flags[7];
            fn          <= res_flags[5];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
